// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer for a 5-stage RV32I pipeline.
//   Issues one-outstanding instruction-memory requests at pc_i.
//   Delivers fetched words to IF/ID, with a skid register for decode stalls.
//   Drives the PC register (pc_next_o / pc_stall_o).
//   Arbitrates EX branches over D jumps and flushes IF/ID on any redirect.
// Ports:
//   clk, rst_n                                   clock, async active-low reset
//   pc_i / pc_next_o / pc_stall_o                PC register interface
//   stall_d_i, halt_i                            decode stall, halt request
//   branch_taken_i/_target_i, jump_i/_target_i   redirect sources
//   imem_req_o/_addr_o, imem_gnt_i, imem_rvalid_i/_rdata_i   instruction memory
//   instr_o, instr_valid_o, flush_d_o            IF/ID interface
//   trap_o                                       misaligned redirect pulse
// Macro FETCH_CTRL_PC_TRAP_EN: misaligned redirect targets go to TRAP_VEC and
// pulse trap_o; otherwise target[1:0] is cleared and trap_o stays 0.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        pc_stall_o,
    input  logic        stall_d_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        halt_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        flush_d_o,
    output logic        trap_o
);
`ifdef FETCH_CTRL_PC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALTED} state_e;

    state_e      state_q, state_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_addr_q, redir_addr_d;
    logic [31:0] skid_q, skid_d;
    logic        redir, misal;
    logic [31:0] raw_tgt, tgt;

    // The EX branch is the older instruction, so it wins over a D jump.
    assign redir   = branch_taken_i | jump_i;
    assign raw_tgt = branch_taken_i ? branch_target_i : jump_target_i;
    assign misal   = redir & (|raw_tgt[1:0]);
    assign tgt     = (TRAP_EN && misal) ? TRAP_VEC : {raw_tgt[31:2], 2'b00};
    assign trap_o  = TRAP_EN & misal;

    always_comb begin
        state_d       = state_q;
        redir_pend_d  = redir_pend_q;
        redir_addr_d  = redir_addr_q;
        skid_d        = skid_q;
        pc_next_o     = pc_i;
        pc_stall_o    = 1'b1;
        imem_req_o    = 1'b0;
        imem_addr_o   = 32'h0;
        instr_o       = 32'h0;
        instr_valid_o = 1'b0;
        flush_d_o     = redir;
        case (state_q)
            IDLE: begin
                state_d    = REQ;
                pc_next_o  = redir ? tgt : RESET_PC;
                pc_stall_o = !redir;
            end
            REQ: begin
                if (redir) begin
                    // Retarget before the request is accepted; re-request next cycle.
                    pc_next_o  = tgt;
                    pc_stall_o = 1'b0;
                end else begin
                    imem_req_o  = 1'b1;
                    imem_addr_o = pc_i;
                    state_d     = imem_gnt_i ? WAIT : (halt_i ? HALTED : REQ);
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    redir_pend_d = 1'b0;
                    if (redir || redir_pend_q) begin
                        // Returning word belongs to the squashed path.
                        pc_next_o  = redir ? tgt : redir_addr_q;
                        pc_stall_o = 1'b0;
                        state_d    = REQ;
                    end else begin
                        instr_o       = imem_rdata_i;
                        instr_valid_o = 1'b1;
                        skid_d        = imem_rdata_i;
                        pc_next_o     = pc_i + 32'd4;
                        pc_stall_o    = stall_d_i;
                        state_d       = stall_d_i ? HOLD : REQ;
                    end
                end else if (redir) begin
                    redir_pend_d = 1'b1;
                    redir_addr_d = tgt;
                end
            end
            HOLD: begin
                instr_o       = redir ? 32'h0 : skid_q;
                instr_valid_o = !redir;
                pc_next_o     = redir ? tgt : pc_i + 32'd4;
                pc_stall_o    = !redir && stall_d_i;
                state_d       = pc_stall_o ? HOLD : REQ;
            end
            HALTED: begin
                pc_next_o  = redir ? tgt : pc_i;
                pc_stall_o = !redir;
                state_d    = halt_i ? HALTED : REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            redir_pend_q <= 1'b0;
            redir_addr_q <= 32'h0;
            skid_q       <= 32'h0;
        end else begin
            state_q      <= state_d;
            redir_pend_q <= redir_pend_d;
            redir_addr_q <= redir_addr_d;
            skid_q       <= skid_d;
        end
    end
endmodule
